neuron_mac: RTL and testbench

Single-neuron multiply-accumulate engine. It produces the 32-bit pre-activation sum that the team's ReLU activation stage consumes.
- Streams NUM_INPUTS Q2.14 activations against a locally stored Q2.14 weight vector.
- Adds a Q2.14 bias, saturates, and presents one Q4.28 result per frame on a valid/ready output.
- Sits between the layer input stream and the activation block; out_data connects directly to the activation block's 2*dataWidth-bit input.

---
 rtl/neuron_mac_if.sv | 30 +++
 rtl/neuron_mac.sv | 138 +++++++++++++
 tb/tb_neuron_mac.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/neuron_mac_if.sv
// Stream and parameter-load bundle for neuron_mac: weight/bias writes,
// the activation input handshake and the result output handshake.
interface neuron_mac_if #(
    parameter int dataWidth = 16,
    parameter int ADDR_W    = 5
);
    logic                   w_wr_en;
    logic [ADDR_W-1:0]      w_addr;
    logic [dataWidth-1:0]   w_data;
    logic                   b_wr_en;
    logic [dataWidth-1:0]   b_data;
    logic                   in_valid;
    logic [dataWidth-1:0]   in_data;
    logic                   in_ready;
    logic                   out_valid;
    logic [2*dataWidth-1:0] out_data;
    logic                   out_ready;

    modport master (
        output w_wr_en, w_addr, w_data, b_wr_en, b_data,
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  w_wr_en, w_addr, w_data, b_wr_en, b_data,
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/neuron_mac.sv
// Single-neuron MAC: streams Q2.14 activations against stored Q2.14 weights,
// adds an aligned bias with saturation and emits one Q4.28 sum per frame.
module neuron_mac #(
    parameter int dataWidth      = 16,
    parameter int weightIntWidth = 2,
    parameter int NUM_INPUTS     = 30,
    parameter int ADDR_W         = 5
) (
    input  logic         clk,
    input  logic         rst,
    neuron_mac_if.slave  bus
);
    localparam int W2   = 2 * dataWidth;
    localparam int FRAC = dataWidth - weightIntWidth;

    localparam logic [1:0] ST_ACC   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_BIAS  = 2'd2;
    localparam logic [1:0] ST_OUT   = 2'd3;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_INPUTS - 1);
    localparam logic [ADDR_W:0]   DEPTH    = (ADDR_W + 1)'(NUM_INPUTS);

    logic [1:0]           state_reg;
    logic [ADDR_W-1:0]    cnt_reg;
    logic [W2-1:0]        acc_reg;
    logic [dataWidth-1:0] bias_reg;
    logic [dataWidth-1:0] x_reg;
    logic [dataWidth-1:0] w_q_reg;
    logic [W2-1:0]        prod_reg;
    logic                 s1_valid_reg;
    logic                 s2_valid_reg;
    logic                 out_valid_reg;
    logic [W2-1:0]        out_data_reg;

    logic [dataWidth-1:0] ram [NUM_INPUTS];

    logic          accept;
    logic          idle;
    logic          w_we;
    logic          b_we;
    logic [W2-1:0] prod_next;
    logic [W2-1:0] bias_ext;
    logic [W2-1:0] acc_sum;
    logic [W2-1:0] bias_sum;

    // Two's-complement add at W2+1 bits, clamped to the W2-bit signed range.
    function automatic logic [W2-1:0] sat_add(input logic [W2-1:0] a, input logic [W2-1:0] b);
        logic [W2:0]   s;
        logic [W2-1:0] r;
        s = {a[W2-1], a} + {b[W2-1], b};
        if (s[W2] != s[W2-1])
            r = s[W2] ? {1'b1, {(W2-1){1'b0}}} : {1'b0, {(W2-1){1'b1}}};
        else
            r = s[W2-1:0];
        return r;
    endfunction

    assign accept = (state_reg == ST_ACC) && bus.in_valid;
    assign idle   = (state_reg == ST_ACC) && (cnt_reg == '0) && !s1_valid_reg && !s2_valid_reg;
    assign w_we   = bus.w_wr_en && idle && ({1'b0, bus.w_addr} < DEPTH);
    assign b_we   = bus.b_wr_en && idle;

    // Sign-extending both operands to W2 bits makes the low W2 bits of an
    // unsigned multiply equal to the signed product.
    assign prod_next = {{dataWidth{x_reg[dataWidth-1]}}, x_reg}
                     * {{dataWidth{w_q_reg[dataWidth-1]}}, w_q_reg};
    assign bias_ext  = {{(W2-dataWidth){bias_reg[dataWidth-1]}}, bias_reg} << FRAC;
    assign acc_sum   = sat_add(acc_reg, prod_reg);
    assign bias_sum  = sat_add(acc_reg, bias_ext);

    assign bus.in_ready  = (state_reg == ST_ACC);
    assign bus.out_valid = out_valid_reg;
    assign bus.out_data  = out_data_reg;

    // Weight store: read-before-write, so a beat alongside a write sees the old word.
    always_ff @(posedge clk) begin
        if (w_we)
            ram[bus.w_addr] <= bus.w_data;
        if (accept)
            w_q_reg <= ram[cnt_reg];
    end

    always_ff @(posedge clk) begin
        if (accept)
            x_reg <= bus.in_data;
        if (s1_valid_reg)
            prod_reg <= prod_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_ACC;
            cnt_reg       <= '0;
            acc_reg       <= '0;
            bias_reg      <= '0;
            s1_valid_reg  <= 1'b0;
            s2_valid_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
        end else begin
            s1_valid_reg <= accept;
            s2_valid_reg <= s1_valid_reg;

            if (accept)
                cnt_reg <= cnt_reg + 1'b1;
            if (b_we)
                bias_reg <= bus.b_data;
            if (s2_valid_reg)
                acc_reg <= acc_sum;

            case (state_reg)
                ST_ACC: begin
                    if (accept && (cnt_reg == LAST_IDX))
                        state_reg <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (!s1_valid_reg && !s2_valid_reg)
                        state_reg <= ST_BIAS;
                end
                ST_BIAS: begin
                    acc_reg       <= bias_sum;
                    out_data_reg  <= bias_sum;
                    out_valid_reg <= 1'b1;
                    state_reg     <= ST_OUT;
                end
                default: begin
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        acc_reg       <= '0;
                        cnt_reg       <= '0;
                        state_reg     <= ST_ACC;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_neuron_mac.sv
// Directed bench for neuron_mac (NUM_INPUTS=4): expected sums are queued at
// stimulus time and a negedge monitor compares them at each output handshake.
module tb_neuron_mac;
    localparam int DW = 16;
    localparam int AW = 2;
    localparam int N  = 4;

    logic clk;
    logic rst;

    neuron_mac_if #(.dataWidth(DW), .ADDR_W(AW)) bus ();

    neuron_mac #(
        .dataWidth(DW), .weightIntWidth(2), .NUM_INPUTS(N), .ADDR_W(AW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q [$];
    logic [DW-1:0] xv [N];
    logic [DW-1:0] wv [N];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end else begin
            $display("ok   %s value=%h", name, act);
        end
    endtask

    // Scoreboard monitor: one comparison per output handshake.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out actual=%h required=none", bus.out_data);
            end else begin
                check("out_data", bus.out_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic load_params(input logic [DW-1:0] bias);
        for (int i = 0; i < N; i++) begin
            bus.w_wr_en = 1'b1;
            bus.w_addr  = AW'(i);
            bus.w_data  = wv[i];
            @(posedge clk); #1;
        end
        bus.w_wr_en = 1'b0;
        bus.b_wr_en = 1'b1;
        bus.b_data  = bias;
        @(posedge clk); #1;
        bus.b_wr_en = 1'b0;
    endtask

    task automatic drive_beat(input logic [DW-1:0] d);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            total++;
            bad++;
            $display("FAIL beat_timeout actual=in_ready_low required=in_ready_high");
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    // Sends xv[], then checks the fixed 4-edge latency and in_ready low
    // through DRAIN/BIAS/OUT; with out_ready high also checks the 1-cycle pulse.
    task automatic send_frame(input logic [31:0] expv, input bit gaps);
        exp_q.push_back(expv);
        for (int i = 0; i < N; i++) begin
            drive_beat(xv[i]);
            if (gaps && i < N - 1)
                repeat (i + 1) begin @(posedge clk); #1; end
        end
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            check($sformatf("lat_valid_e%0d", k), {31'b0, bus.out_valid}, {31'b0, k == 4});
            check($sformatf("lat_ready_e%0d", k), {31'b0, bus.in_ready}, 32'd0);
        end
        if (bus.out_ready) begin
            @(posedge clk); #1;
            check("pulse_end_valid", {31'b0, bus.out_valid}, 32'd0);
            check("ready_back", {31'b0, bus.in_ready}, 32'd1);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.w_wr_en = 1'b0; bus.w_addr = '0; bus.w_data = '0;
        bus.b_wr_en = 1'b0; bus.b_data = '0;
        bus.in_valid = 1'b0; bus.in_data = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("rst_out_data", bus.out_data, 32'd0);
        check("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);

        // 1.0 * 0.5 * 4 = 2.0
        wv = '{16'h4000, 16'h4000, 16'h4000, 16'h4000};
        load_params(16'h0000);
        xv = '{16'h2000, 16'h2000, 16'h2000, 16'h2000};
        send_frame(32'h2000_0000, 1'b0);

        // plus bias 0.25, with gaps between beats
        load_params(16'h1000);
        send_frame(32'h2400_0000, 1'b1);

        // positive clamp
        wv = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
        load_params(16'h0000);
        xv = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
        send_frame(32'h7FFF_FFFF, 1'b0);

        // negative clamp
        wv = '{16'h8000, 16'h8000, 16'h8000, 16'h8000};
        load_params(16'h0000);
        send_frame(32'h8000_0000, 1'b0);

        // backpressure: 1 - 1 + 0.5 + 0.25 = 0.75, held while in_valid toggles
        wv = '{16'h4000, 16'h4000, 16'h4000, 16'h4000};
        load_params(16'h0000);
        xv = '{16'h4000, 16'hC000, 16'h2000, 16'h1000};
        bus.out_ready = 1'b0;
        send_frame(32'h0C00_0000, 1'b0);
        for (int k = 0; k < 5; k++) begin
            bus.in_valid = k[0];
            bus.in_data  = 16'h7FFF;
            @(posedge clk); #1;
            check("hold_valid", {31'b0, bus.out_valid}, 32'd1);
            check("hold_data", bus.out_data, 32'h0C00_0000);
            check("hold_ready", {31'b0, bus.in_ready}, 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("release_valid", {31'b0, bus.out_valid}, 32'd0);
        xv = '{16'h2000, 16'h2000, 16'h2000, 16'h2000};
        send_frame(32'h2000_0000, 1'b0);

        // reset after two beats; weight write at cnt=2 must be ignored
        drive_beat(16'h4000);
        drive_beat(16'h4000);
        bus.w_wr_en = 1'b1; bus.w_addr = '0; bus.w_data = 16'h7FFF;
        @(posedge clk); #1;
        bus.w_wr_en = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("midrst_in_ready", {31'b0, bus.in_ready}, 32'd1);
        // 1 + 0.5 + 0.25 + 0.125 = 1.875
        xv = '{16'h4000, 16'h2000, 16'h1000, 16'h0800};
        send_frame(32'h1E00_0000, 1'b0);
        // unit input on index 0 reads back w[0] = 1.0
        xv = '{16'h4000, 16'h0000, 16'h0000, 16'h0000};
        send_frame(32'h1000_0000, 1'b0);

        repeat (3) @(posedge clk);
        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
